mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-stage access controller between the pipeline MEM stage and the data cache. It converts the MEM stage's load/store control into the cache request handshake and captures the request on a miss. It holds the pipeline with a stall signal until the cache reports a hit, and optionally counts hits and misses for performance analysis.

## Interface
Parameters:
- `WORD_WIDTH`, default 32: data and address width.
- `CNT_WIDTH`, default 32: width of the statistics counters. Used only with `MEM_CTRL_STATS_EN`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  MEM-stage load request.
- `mem_write`  in  1  MEM-stage store request. Never asserted together with `mem_read`.
- `addr`  in  WORD_WIDTH  byte address from the MEM stage; word-aligned.
- `din`  in  WORD_WIDTH  store data.
- `dout`  out  WORD_WIDTH  load data returned to the pipeline.
- `mem_stall`  out  1  high to freeze the pipeline up to and including the MEM stage.
- `cache_input_valid`  out  1  request valid to the cache.
- `cache_mem_rw`  out  1  1 = write, 0 = read.
- `cache_addr`  out  WORD_WIDTH  request address to the cache.
- `cache_din`  out  WORD_WIDTH  request write data to the cache.
- `cache_is_ready`  in  1  cache idle and able to accept a request.
- `cache_is_hit`  in  1  combinational hit for the presented address.
- `cache_dout`  in  WORD_WIDTH  combinational read data from the cache.
- `hit_count`  out  CNT_WIDTH  completed accesses with no miss. Present only with `MEM_CTRL_STATS_EN`.
- `miss_count`  out  CNT_WIDTH  accesses that missed at least once. Present only with `MEM_CTRL_STATS_EN`.

## Operation
State machine, 2-bit encoding:

- **IDLE**
  - The request comes straight from the pipeline inputs: `cache_input_valid` = `mem_read|mem_write`, `cache_mem_rw` = `mem_write`, and `cache_addr`/`cache_din` = `addr`/`din`.
  - The access completes this cycle if a request is present and `cache_is_ready && cache_is_hit`. In that case `mem_stall` = 0, `dout` = `cache_dout`, and the state stays IDLE.
  - Otherwise, if a request is present: `mem_stall` = 1, the request is latched into `req_rw`/`req_addr`/`req_din`, and the state goes to MISS_WAIT.
- **MISS_WAIT**
  - Drives the latched request with `cache_input_valid` = 1 and `mem_stall` = 1.
  - Goes to RETRY on the first cycle that `cache_is_ready` = 1.
- **RETRY**
  - Drives the latched request.
  - If `cache_is_ready && cache_is_hit`: the access completes with `mem_stall` = 0 and `dout` = `cache_dout`, then go to IDLE.
  - Otherwise: `mem_stall` = 1 and go back to MISS_WAIT. There is no retry limit.

Other rules:
- `dout` is valid only in a completing cycle for a read; it is don't-care otherwise and drives 0 when no read completes.
- The latched request is used outside IDLE, so later changes on the pipeline inputs are ignored until the access completes.
- A store completes on the edge that ends its completing cycle; the cache writes on that same edge. The controller never issues a second write for the same store.

## Timing
- Reset values: state IDLE, latched request 0, counters 0. During a reset cycle `mem_stall` = 0 and `cache_input_valid` = 0, regardless of inputs.
- Hit latency is 0 extra cycles: `mem_stall` stays low and the access completes in the cycle it is presented.
- Miss latency is 1 cycle (IDLE) + N cycles (MISS_WAIT, until `cache_is_ready`) + 1 cycle (RETRY). `mem_stall` is high for all of these except the final completing cycle.
- A request in IDLE while `cache_is_ready` = 0 is treated as a miss.
- Back-to-back hits complete one per cycle.
- Reset asserted in MISS_WAIT or RETRY abandons the latched request and returns to IDLE on the next edge; nothing is counted for it.

## Configuration
- `MEM_CTRL_STATS_EN` defined:
  - `hit_count` increments on each completion from IDLE.
  - `miss_count` increments once per access, on the IDLE→MISS_WAIT transition; a RETRY→MISS_WAIT loop does not count again.
  - Both counters saturate at all-ones.
- `MEM_CTRL_STATS_EN` undefined: no counter logic and no `hit_count`/`miss_count` ports. All other behaviour is identical.

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - state encodings `MC_IDLE` = 2'b00, `MC_MISS_WAIT` = 2'b01, `MC_RETRY` = 2'b10;
  - default widths.
- Sub-module `mem_access_stats` contains the two saturating counters, with inputs `hit_evt` and `miss_evt`. It is instantiated only under `MEM_CTRL_STATS_EN`.

## Test plan
- **Read hit:** `mem_read` = 1, `addr` = 0x100, cache hit with `cache_dout` = 0xDEADBEEF → same cycle `mem_stall` = 0, `dout` = 0xDEADBEEF; `hit_count` = 1.
- **Read miss:** `addr` = 0x200, hit = 0, then `cache_is_ready` held low for 5 cycles →
  - `mem_stall` high for 7 cycles;
  - `cache_addr` stays 0x200 even after the pipeline `addr` is changed to 0x300;
  - completes in RETRY; `miss_count` = 1.
- **Store miss then hit:** `mem_write`, `addr` = 0x40, `din` = 0x12345678 → `cache_mem_rw` = 1 throughout, `cache_din` = 0x12345678; exactly one completing cycle.
- **Retry loop:** RETRY sees hit = 0 twice before a hit → the FSM returns to MISS_WAIT twice; `miss_count` increments only once.
- **Reset mid-miss:** assert `reset` in MISS_WAIT → next cycle IDLE, `mem_stall` = 0, `cache_input_valid` = 0, counters = 0.
- **Saturation:** with `CNT_WIDTH` = 4, 20 hits → `hit_count` = 15.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: FSM state
// encodings and default datapath/counter widths.
package mem_ctrl_pkg;

  localparam int MC_WORD_WIDTH = 32;
  localparam int MC_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    MC_IDLE      = 2'b00,
    MC_MISS_WAIT = 2'b01,
    MC_RETRY     = 2'b10
  } mc_state_e;

endpackage

// File: rtl/mem_access_stats.sv
// Saturating hit/miss counters for the MEM-stage access controller.
// Only instantiated when MEM_CTRL_STATS_EN is defined.
module mem_access_stats
  import mem_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = MC_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hit_evt,
  input  logic                 miss_evt,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] hit_q, hit_d;
  logic [CNT_WIDTH-1:0] miss_q, miss_d;

  // Next counts: increment on an event, hold once all-ones is reached
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (hit_evt && (hit_q != CNT_MAX)) hit_d = hit_q + CNT_ONE;
    if (miss_evt && (miss_q != CNT_MAX)) miss_d = miss_q + CNT_ONE;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: turns load/store control into the data
// cache request handshake, latches the request on a miss and stalls the
// pipeline until the cache reports a hit.
// Optional feature macro: MEM_CTRL_STATS_EN adds hit/miss counters and the
// hit_count/miss_count ports.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH = MC_WORD_WIDTH,
  parameter int CNT_WIDTH  = MC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WORD_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] din,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  mem_stall,
  output logic                  cache_input_valid,
  output logic                  cache_mem_rw,
  output logic [WORD_WIDTH-1:0] cache_addr,
  output logic [WORD_WIDTH-1:0] cache_din,
  input  logic                  cache_is_ready,
  input  logic                  cache_is_hit,
  input  logic [WORD_WIDTH-1:0] cache_dout
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
`endif
);

  mc_state_e             state_q, state_d;
  logic                  req_rw_q;
  logic [WORD_WIDTH-1:0] req_addr_q;
  logic [WORD_WIDTH-1:0] req_din_q;
  logic                  latch_req;
  logic                  req;
  logic                  cache_ok;

  assign req      = mem_read | mem_write;
  assign cache_ok = cache_is_ready & cache_is_hit;

  // Request mux, stall/data outputs and next state; reset masks the handshake
  always_comb begin
    state_d           = state_q;
    latch_req         = 1'b0;
    mem_stall         = 1'b0;
    dout              = '0;
    cache_input_valid = 1'b0;
    cache_mem_rw      = 1'b0;
    cache_addr        = '0;
    cache_din         = '0;
    unique case (state_q)
      MC_IDLE: begin
        cache_input_valid = req;
        cache_mem_rw      = mem_write;
        cache_addr        = addr;
        cache_din         = din;
        if (req) begin
          if (cache_ok) begin
            if (mem_read) dout = cache_dout;
          end else begin
            mem_stall = 1'b1;
            latch_req = 1'b1;
            state_d   = MC_MISS_WAIT;
          end
        end
      end
      MC_MISS_WAIT: begin
        cache_input_valid = 1'b1;
        cache_mem_rw      = req_rw_q;
        cache_addr        = req_addr_q;
        cache_din         = req_din_q;
        mem_stall         = 1'b1;
        if (cache_is_ready) state_d = MC_RETRY;
      end
      MC_RETRY: begin
        cache_input_valid = 1'b1;
        cache_mem_rw      = req_rw_q;
        cache_addr        = req_addr_q;
        cache_din         = req_din_q;
        if (cache_ok) begin
          if (!req_rw_q) dout = cache_dout;
          state_d = MC_IDLE;
        end else begin
          mem_stall = 1'b1;
          state_d   = MC_MISS_WAIT;
        end
      end
      default: state_d = MC_IDLE;
    endcase
    if (reset) begin
      mem_stall         = 1'b0;
      cache_input_valid = 1'b0;
      dout              = '0;
      latch_req         = 1'b0;
      state_d           = MC_IDLE;
    end
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MC_IDLE;
      req_rw_q   <= 1'b0;
      req_addr_q <= '0;
      req_din_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        req_rw_q   <= mem_write;
        req_addr_q <= addr;
        req_din_q  <= din;
      end
    end
  end

`ifdef MEM_CTRL_STATS_EN
  logic hit_evt;
  logic miss_evt;

  // A hit counts only when completed straight from IDLE; a miss counts once
  // on entry to MISS_WAIT from IDLE, never on the retry loop
  assign hit_evt  = !reset && (state_q == MC_IDLE) && req && cache_ok;
  assign miss_evt = !reset && (state_q == MC_IDLE) && req && !cache_ok;

  mem_access_stats #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stats (
    .clk        (clk),
    .reset      (reset),
    .hit_evt    (hit_evt),
    .miss_evt   (miss_evt),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`endif

endmodule
